// File: rtl/sim_uart_pkg.sv
// Shared types and width helpers for the simulation-side UART host.
package sim_uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // RX_BREAK holds off re-arming after a low stop bit until the line returns high.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    function automatic int bit_cnt_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

    function automatic int baud_cnt_width(input int clk_div);
        return $clog2(clk_div);
    endfunction

endpackage

// File: rtl/sim_uart_fifo.sv
// Synchronous FIFO with valid/ready on both sides and combinational head output.
module sim_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;

    // A pop in the same cycle frees the slot, so a full FIFO may still take a push.
    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign in_ready  = !full;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!full || pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sim_uart_host.sv
// Harness-side UART endpoint: host byte FIFOs, TX serialiser, RX deserialiser,
// and a free-running cycle counter with optional timeout flag.
module sim_uart_host #(
    parameter int          CLK_DIV        = 16,
    parameter int          DATA_BITS      = 8,
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [63:0] TIMEOUT_CYCLES = 64'd0
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 uart_rxd,
    input  logic                 uart_txd,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    output logic                 rx_overflow,
    output logic                 rx_frame_err,
    output logic [63:0]          cycles,
    output logic                 timeout
);

    import sim_uart_pkg::*;

    localparam int                BAUD_W    = baud_cnt_width(CLK_DIV);
    localparam int                BIT_W     = bit_cnt_width(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 txf_valid;
    logic [DATA_BITS-1:0] txf_data;
    logic                 tx_pop;
    tx_state_t            tx_state, tx_state_next;
    logic [BAUD_W-1:0]    tx_baud, tx_baud_next;
    logic [BIT_W-1:0]     tx_bit, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_next;

    logic                 rx_sync1, rx_sync2, rx_prev;
    logic                 rxf_ready;
    logic                 rx_push;
    logic                 rx_ferr_set;
    rx_state_t            rx_state, rx_state_next;
    logic [BAUD_W-1:0]    rx_baud, rx_baud_next;
    logic [BIT_W-1:0]     rx_bit, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_next;

    sim_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (tx_valid && tx_ready),
        .in_data   (tx_data),
        .in_ready  (tx_ready),
        .out_valid (txf_valid),
        .out_data  (txf_data),
        .out_ready (tx_pop)
    );

    sim_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (rx_push),
        .in_data   (rx_shift),
        .in_ready  (rxf_ready),
        .out_valid (rx_valid),
        .out_data  (rx_data),
        .out_ready (rx_ready)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_next;
            tx_baud  <= tx_baud_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
        end
    end

    // The last STOP cycle fetches the next byte directly, so queued bytes go out gap-free.
    always_comb begin
        tx_state_next = tx_state;
        tx_baud_next  = tx_baud + BAUD_W'(1);
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_pop        = 1'b0;
        uart_rxd      = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_baud_next = '0;
                if (txf_valid) begin
                    tx_pop        = 1'b1;
                    tx_shift_next = txf_data;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                uart_rxd = 1'b0;
                if (tx_baud == BAUD_LAST) begin
                    tx_baud_next  = '0;
                    tx_bit_next   = '0;
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                uart_rxd = tx_shift[0];
                if (tx_baud == BAUD_LAST) begin
                    tx_baud_next  = '0;
                    tx_shift_next = tx_shift >> 1;
                    tx_bit_next   = tx_bit + BIT_W'(1);
                    if (tx_bit == BIT_LAST) begin
                        tx_state_next = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tx_baud == BAUD_LAST) begin
                    tx_baud_next = '0;
                    if (txf_valid) begin
                        tx_pop        = 1'b1;
                        tx_shift_next = txf_data;
                        tx_state_next = TX_START;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync1 <= uart_txd;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
            rx_state <= rx_state_next;
            rx_baud  <= rx_baud_next;
            rx_bit   <= rx_bit_next;
            rx_shift <= rx_shift_next;
        end
    end

    // Start bit is re-checked at mid-bit; later samples then land mid-bit every CLK_DIV cycles.
    always_comb begin
        rx_state_next = rx_state;
        rx_baud_next  = rx_baud + BAUD_W'(1);
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        rx_push       = 1'b0;
        rx_ferr_set   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_baud_next = '0;
                if (rx_prev && !rx_sync2) begin
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_baud == BAUD_HALF) begin
                    rx_baud_next  = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_baud == BAUD_LAST) begin
                    rx_baud_next  = '0;
                    rx_shift_next = {rx_sync2, rx_shift[DATA_BITS-1:1]};
                    rx_bit_next   = rx_bit + BIT_W'(1);
                    if (rx_bit == BIT_LAST) begin
                        rx_state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_baud == BAUD_LAST) begin
                    rx_baud_next = '0;
                    if (rx_sync2) begin
                        rx_push       = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_ferr_set   = 1'b1;
                        rx_state_next = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                rx_baud_next = '0;
                if (rx_sync2) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_overflow  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_push && !rxf_ready && !(rx_valid && rx_ready)) begin
                rx_overflow <= 1'b1;
            end
            if (rx_ferr_set) begin
                rx_frame_err <= 1'b1;
            end
        end
    end

    // Timeout is raised on the same edge that brings cycles to TIMEOUT_CYCLES.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycles  <= '0;
            timeout <= 1'b0;
        end else begin
            cycles <= cycles + 64'd1;
            if ((TIMEOUT_CYCLES != 64'd0) && (cycles + 64'd1 == TIMEOUT_CYCLES)) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sim_uart_host.sv
// Scoreboard bench for sim_uart_host: TX timing, loopback, RX errors, reset and timeout.
module tb_sim_uart_host;

    localparam int CLK_DIV    = 8;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        uart_rxd;
    logic        txd_line;
    logic        drv_txd;
    logic        loopback;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_overflow;
    logic        rx_frame_err;
    logic [63:0] cycles;
    logic        timeout;

    logic        nt_uart_rxd;
    logic        nt_tx_ready;
    logic        nt_rx_valid;
    logic [7:0]  nt_rx_data;
    logic        nt_rx_overflow;
    logic        nt_rx_frame_err;
    logic [63:0] nt_cycles;
    logic        nt_timeout;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          tb_cyc   = 0;
    logic [7:0]  exp_q[$];

    assign txd_line = loopback ? uart_rxd : drv_txd;

    sim_uart_host #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT_CYCLES(64'd1000)
    ) dut (
        .clock(clock), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(txd_line),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err),
        .cycles(cycles), .timeout(timeout)
    );

    sim_uart_host #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT_CYCLES(64'd0)
    ) dut_nt (
        .clock(clock), .reset(reset), .uart_rxd(nt_uart_rxd), .uart_txd(txd_line),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(nt_tx_ready),
        .rx_valid(nt_rx_valid), .rx_data(nt_rx_data), .rx_ready(rx_ready),
        .rx_overflow(nt_rx_overflow), .rx_frame_err(nt_rx_frame_err),
        .cycles(nt_cycles), .timeout(nt_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) tb_cyc <= tb_cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every byte the host pops is matched against the oldest expected byte.
    always @(negedge clock) begin
        if (!reset && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("rx_unexpected", 64'd1, 64'd0);
            end else begin
                checkOutput("rx_data", rx_data, exp_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d);
        int guard;
        guard = 0;
        @(posedge clock); #1;
        while (!tx_ready && guard < 1000) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!tx_ready) checkOutput("tx_ready_wait", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clock); #1;
        tx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        @(posedge clock); #1;
        for (int i = 0; i < 10; i++) begin
            drv_txd = f[i];
            repeat (CLK_DIV) @(posedge clock);
            #1;
        end
        drv_txd = 1'b1;
    endtask

    task automatic wait_rx_empty(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
        checkOutput("rx_drain", exp_q.size(), 0);
    endtask

    task automatic wait_cyc(input int target);
        do @(negedge clock); while (tb_cyc < target);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] lb [4];
        logic [7:0] ob [6];
        logic       exp_bit;
        int         s;
        int         found;
        int         held;

        lb = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        reset = 1'b1; loopback = 1'b0; drv_txd = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_uart_rxd", uart_rxd, 1);
        checkOutput("rst_tx_ready", tx_ready, 1);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_rx_data", rx_data, 0);
        checkOutput("rst_overflow", rx_overflow, 0);
        checkOutput("rst_frame_err", rx_frame_err, 0);
        checkOutput("rst_cycles", cycles, 0);
        checkOutput("rst_timeout", timeout, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); @(negedge clock);
        checkOutput("cycles_first", cycles, 1);

        $display("[TB] TX waveform of 0x55");
        v = 8'h55;
        applyStimulus(v);
        @(negedge clock);
        checkOutput("tx55_pop_cycle", uart_rxd, 1);
        for (int c = 1; c <= 81; c++) begin
            @(negedge clock);
            if (c <= 8)       exp_bit = 1'b0;
            else if (c <= 72) exp_bit = v[(c - 9) / 8];
            else              exp_bit = 1'b1;
            checkOutput($sformatf("tx55_c%0d", c), uart_rxd, exp_bit);
        end

        $display("[TB] Loopback of four bytes");
        loopback = 1'b1;
        rx_ready = 1'b1;
        exp_q.push_back(lb[0]);
        applyStimulus(lb[0]);
        found = -1;
        s = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (uart_rxd == 1'b0) begin
                found = i;
                s = tb_cyc;
                break;
            end
        end
        checkOutput("lb_start_latency", found, 1);
        for (int k = 1; k < 4; k++) begin
            exp_q.push_back(lb[k]);
            applyStimulus(lb[k]);
        end
        v = lb[0];
        for (int i = 0; i < 8; i++) begin
            wait_cyc(s + 12 + 8 * i);
            checkOutput($sformatf("lb_a5_bit%0d", i), uart_rxd, v[i]);
        end
        for (int k = 1; k < 4; k++) begin
            wait_cyc(s + 80 * k - 1);
            checkOutput($sformatf("lb_stop_end%0d", k), uart_rxd, 1);
            wait_cyc(s + 80 * k);
            checkOutput($sformatf("lb_next_start%0d", k), uart_rxd, 0);
        end
        wait_cyc(s + 320);
        checkOutput("lb_idle_after", uart_rxd, 1);
        wait_rx_empty(200);
        checkOutput("lb_overflow", rx_overflow, 0);
        checkOutput("lb_frame_err", rx_frame_err, 0);
        loopback = 1'b0;

        $display("[TB] Framing error and glitch");
        send_frame(8'h81, 1'b0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        checkOutput("ferr_flag", rx_frame_err, 1);
        checkOutput("ferr_no_push", rx_valid, 0);
        checkOutput("ferr_overflow", rx_overflow, 0);
        @(posedge clock); #1;
        drv_txd = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        drv_txd = 1'b1;
        repeat (30) @(posedge clock);
        @(negedge clock);
        checkOutput("glitch_no_push", rx_valid, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_rx_empty(40);

        $display("[TB] RX overflow with host stalled");
        @(posedge clock); #1;
        rx_ready = 1'b0;
        held = 0;
        for (int i = 0; i < 6; i++) begin
            if (held < FIFO_DEPTH) begin
                exp_q.push_back(ob[i]);
                held++;
            end
            send_frame(ob[i], 1'b1);
            if (i == 3) begin
                @(negedge clock);
                checkOutput("ovf_not_yet", rx_overflow, 0);
            end
        end
        repeat (4) @(posedge clock);
        @(negedge clock);
        checkOutput("ovf_flag", rx_overflow, 1);
        checkOutput("ovf_valid", rx_valid, 1);
        checkOutput("ovf_head", rx_data, exp_q[0]);
        @(posedge clock); #1;
        rx_ready = 1'b1;
        wait_rx_empty(20);
        @(posedge clock); @(negedge clock);
        checkOutput("ovf_drained", rx_valid, 0);

        $display("[TB] Reset mid TX frame, then timeout");
        applyStimulus(8'hC3);
        applyStimulus(8'h3C);
        @(negedge clock);
        checkOutput("rst_mid_line_low", uart_rxd, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        checkOutput("rst_mid_uart_rxd", uart_rxd, 1);
        checkOutput("rst_mid_tx_ready", tx_ready, 1);
        checkOutput("rst_mid_cycles", cycles, 0);
        checkOutput("rst_mid_flags", {rx_overflow, rx_frame_err}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int n = 1; n <= 1010; n++) begin
            @(posedge clock); @(negedge clock);
            if (n == 20) checkOutput("post_rst_idle", uart_rxd, 1);
            if (n == 999) begin
                checkOutput("to_before", timeout, 0);
                checkOutput("to_cycles999", cycles, 999);
            end
            if (n == 1000) begin
                checkOutput("to_rise", timeout, 1);
                checkOutput("to_cycles1000", cycles, 1000);
            end
            if (n == 1010) begin
                checkOutput("to_sticky", timeout, 1);
                checkOutput("to_disabled", nt_timeout, 0);
                checkOutput("nt_cycles", nt_cycles, 1010);
            end
        end
        checkOutput("nt_uart_rxd", nt_uart_rxd, 1);
        checkOutput("nt_tx_ready", nt_tx_ready, 1);
        checkOutput("nt_rx_idle", {nt_rx_valid, nt_rx_data}, 0);
        checkOutput("nt_flags", {nt_rx_overflow, nt_rx_frame_err}, 0);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
